// File: rtl/hazard_mdu.sv
// rtl/hazard_mdu.sv - MIPS hazard unit with forwarding, stalls and a multiply/divide busy tracker.
// Optional HAZARD_PERF_EN builds saturating stall performance counters.
module hazard_mdu #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              MemtoRegM,
    input  logic              BranchD,
    input  logic              bneD,
    input  logic              jrD,
    input  logic              mdStartD,
    input  logic              mfhiloD,
    input  logic              mdStartE,
    input  logic              mdOpE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              mdBusy,
    output logic              mdDone,
    output logic [31:0]       stallCount,
    output logic [31:0]       mdStallCount
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t     state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic          done_nx;
    logic          load_stall, branch_stall, jr_stall, md_stall;

    // Specifier 0 is hardwired zero, so it never forms a dependency.
    function automatic logic hit(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
        return (src != '0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (RegWriteM && hit(WriteRegM, src))
            return 2'b10;
        else if (RegWriteW && hit(WriteRegW, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(rsE);
    assign ForwardBE = fwd_sel(rtE);
    assign ForwardAD = RegWriteM && hit(WriteRegM, rsD);
    assign ForwardBD = RegWriteM && hit(WriteRegM, rtD);

    assign load_stall   = MemtoRegE && RegWriteE && (hit(WriteRegE, rsD) || hit(WriteRegE, rtD));
    assign branch_stall = (BranchD || bneD) &&
                          ((RegWriteE && (hit(WriteRegE, rsD) || hit(WriteRegE, rtD))) ||
                           (MemtoRegM && (hit(WriteRegM, rsD) || hit(WriteRegM, rtD))));
    assign jr_stall     = jrD && ((RegWriteE && hit(WriteRegE, rsD)) ||
                                  (MemtoRegM && hit(WriteRegM, rsD)));
    assign md_stall     = (mdStartD || mfhiloD) &&
                          (mdStartE || ((state == BUSY) && (count != '0)));

    assign FlushE = load_stall || branch_stall || jr_stall || md_stall;
    assign StallD = FlushE;
    assign StallF = StallD;
    assign mdBusy = (state == BUSY) || mdStartE;

    always_comb begin
        state_nx = state;
        count_nx = count;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (mdStartE) begin
                    state_nx = BUSY;
                    count_nx = mdOpE ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (count != '0) begin
                    count_nx = count - CW'(1);
                end else begin
                    done_nx = 1'b1;
                    // A start landing on the completing cycle chains straight into the next op.
                    if (mdStartE)
                        count_nx = mdOpE ? DIV_LOAD : MUL_LOAD;
                    else
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            mdDone <= 1'b0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            mdDone <= done_nx;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, md_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (FlushE && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (md_stall && (md_stall_cnt != '1))
                md_stall_cnt <= md_stall_cnt + 32'd1;
        end
    end

    assign stallCount   = stall_cnt;
    assign mdStallCount = md_stall_cnt;
`else
    assign stallCount   = '0;
    assign mdStallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_mdu.sv
// tb/tb_hazard_mdu.sv - Self-checking bench for hazard_mdu against a cycle-numbered reference model.
module tb_hazard_mdu;
    localparam int REG_AW  = 5;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic clk = 1'b0;
    logic reset;
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic BranchD, bneD, jrD, mdStartD, mfhiloD, mdStartE, mdOpE;
    logic ForwardAD, ForwardBD, StallF, StallD, FlushE, mdBusy, mdDone;
    logic [1:0] ForwardAE, ForwardBE;
    logic [31:0] stallCount, mdStallCount;

    always #5 clk = ~clk;

    hazard_mdu #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .bneD(bneD), .jrD(jrD),
        .mdStartD(mdStartD), .mfhiloD(mfhiloD), .mdStartE(mdStartE), .mdOpE(mdOpE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .mdBusy(mdBusy), .mdDone(mdDone),
        .stallCount(stallCount), .mdStallCount(mdStallCount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: the MDU is busy in absolute cycles start_c+1 .. end_c; mdDone in cycle done_at.
    int cyc = 0;
    int start_c, end_c, done_at;
    logic [31:0] stall_ref, md_ref;

    function automatic void model_clear();
        start_c   = -100;
        end_c     = -100;
        done_at   = -100;
        stall_ref = 0;
        md_ref    = 0;
    endfunction

    function automatic logic m_busy();
        return (start_c < cyc) && (cyc <= end_c);
    endfunction

    function automatic logic m_match(input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] s);
        return (s != 0) && (d == s);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [REG_AW-1:0] s);
        if (RegWriteM && m_match(WriteRegM, s)) return 2'b10;
        if (RegWriteW && m_match(WriteRegW, s)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_md();
        return (mdStartD || mfhiloD) && (mdStartE || (m_busy() && cyc < end_c));
    endfunction

    function automatic logic m_flush();
        logic ld, br, jr;
        ld = MemtoRegE && RegWriteE && (m_match(WriteRegE, rsD) || m_match(WriteRegE, rtD));
        br = (BranchD || bneD) &&
             ((RegWriteE && (m_match(WriteRegE, rsD) || m_match(WriteRegE, rtD))) ||
              (MemtoRegM && (m_match(WriteRegM, rsD) || m_match(WriteRegM, rtD))));
        jr = jrD && ((RegWriteE && m_match(WriteRegE, rsD)) || (MemtoRegM && m_match(WriteRegM, rsD)));
        return ld || br || jr || m_md();
    endfunction

    task automatic sample();
        logic f;
        @(negedge clk);
        f = m_flush();
        check("fwdAE", 32'(ForwardAE), 32'(m_fwd(rsE)));
        check("fwdBE", 32'(ForwardBE), 32'(m_fwd(rtE)));
        check("fwdAD", 32'(ForwardAD), 32'(RegWriteM && m_match(WriteRegM, rsD)));
        check("fwdBD", 32'(ForwardBD), 32'(RegWriteM && m_match(WriteRegM, rtD)));
        check("flushE", 32'(FlushE), 32'(f));
        check("stallD", 32'(StallD), 32'(f));
        check("stallF", 32'(StallF), 32'(f));
        check("mdBusy", 32'(mdBusy), 32'(m_busy() || mdStartE));
        check("mdDone", 32'(mdDone), 32'(cyc == done_at));
`ifdef HAZARD_PERF_EN
        check("stallCount", stallCount, stall_ref);
        check("mdStallCount", mdStallCount, md_ref);
`else
        check("stallCount", stallCount, 32'd0);
        check("mdStallCount", mdStallCount, 32'd0);
`endif
    endtask

    task automatic advance();
        logic b, f, md;
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            b  = m_busy();
            f  = m_flush();
            md = m_md();
            if (b && cyc == end_c) done_at = cyc + 1;
            if (mdStartE && (!b || cyc == end_c)) begin
                start_c = cyc;
                end_c   = cyc + (mdOpE ? DIV_LAT : MUL_LAT);
            end
            if (f && stall_ref != 32'hFFFF_FFFF) stall_ref++;
            if (md && md_ref != 32'hFFFF_FFFF) md_ref++;
        end
        cyc++;
        #1;
    endtask

    task automatic zero_inputs();
        {rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
        {BranchD, bneD, jrD, mdStartD, mfhiloD, mdStartE, mdOpE} = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_clear();
        advance();
        reset = 1'b1;
    endtask

    initial begin
        int flushes, dones, lat;
        logic fin;
        reset = 1'b0;
        zero_inputs();
        model_clear();
        sample();
        check("rst_busy", 32'(mdBusy), 32'd0);
        check("rst_done", 32'(mdDone), 32'd0);
        advance();
        sample();
        advance();
        reset = 1'b1;

        // Forwarding priority and register zero
        rsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
        sample();
        check("fwd_m_prio", 32'(ForwardAE), 32'h2);
        advance();
        rsE = 0;
        sample();
        check("fwd_reg0", 32'(ForwardAE), 32'h0);
        advance();
        zero_inputs();

        // Load-use: one stall cycle
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; rtD = 8;
        sample();
        check("ld_stall", 32'({StallF, StallD, FlushE}), 32'h7);
        advance();
        MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0;
        MemtoRegM = 1; RegWriteM = 1; WriteRegM = 8;
        sample();
        check("ld_once", 32'(FlushE), 32'h0);
        advance();
        zero_inputs();

        // beq behind an ALU producer: one stall then M-stage forward
        BranchD = 1; rsD = 3; RegWriteE = 1; WriteRegE = 3;
        sample();
        check("br_stall", 32'(FlushE), 32'h1);
        advance();
        RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3;
        sample();
        check("br_once", 32'(FlushE), 32'h0);
        check("br_fwdAD", 32'(ForwardAD), 32'h1);
        advance();
        zero_inputs();

        // Divide then dependent mflo held in D
        mdStartE = 1; mdOpE = 1; mfhiloD = 1;
        flushes = 0; dones = 0; fin = 0;
        for (int k = 0; k < 100 && !fin; k++) begin
            sample();
            if (FlushE) flushes++; else fin = 1;
            if (mdDone) dones++;
            advance();
            mdStartE = 0; mdOpE = 0;
        end
        check("div_no_timeout", 32'(fin), 32'h1);
        check("div_stall_len", 32'(flushes), 32'(DIV_LAT));
        mfhiloD = 0;
        sample();
        check("mflo_e_with_done", 32'(mdDone), 32'h1);
        if (mdDone) dones++;
        advance();
        sample();
        if (mdDone) dones++;
        check("div_done_once", 32'(dones), 32'h1);
        advance();

        // Reset during a divide at count 10
        mdStartE = 1; mdOpE = 1;
        sample();
        advance();
        mdStartE = 0; mdOpE = 0;
        for (int k = 0; k < 21; k++) begin
            sample();
            advance();
        end
        sample();
        reset = 1'b0;
        #1;
        model_clear();
        check("rst_mid_busy", 32'(mdBusy), 32'h0);
        advance();
        reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (mdDone) dones++;
            advance();
        end
        check("abort_no_done", 32'(dones), 32'h0);
        mdStartE = 1;
        sample();
        advance();
        mdStartE = 0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            sample();
            if (mdDone) begin
                lat = k;
                break;
            end
            advance();
        end
        check("mul_after_rst_lat", 32'(lat), 32'(MUL_LAT + 1));
        advance();

        // Performance counters: 3 load-use stalls plus a multiply stall
        do_reset();
        for (int i = 0; i < 3; i++) begin
            MemtoRegE = 1; RegWriteE = 1; WriteRegE = 9; rsD = 9;
            sample();
            advance();
            zero_inputs();
            sample();
            advance();
        end
        mdStartE = 1; mfhiloD = 1;
        sample();
        advance();
        mdStartE = 0;
        for (int k = 0; k < 20; k++) begin
            sample();
            if (!FlushE) break;
            advance();
        end
        mfhiloD = 0;
        advance();
        sample();
`ifdef HAZARD_PERF_EN
        check("perf_stall", stallCount, 32'd7);
        check("perf_md", mdStallCount, 32'd4);
`else
        check("perf_stall_off", stallCount, 32'd0);
        check("perf_md_off", mdStallCount, 32'd0);
`endif
        advance();

        // Random traffic with occasional asynchronous resets
        for (int k = 0; k < 3000; k++) begin
            rsD = REG_AW'($urandom_range(0, 3)); rtD = REG_AW'($urandom_range(0, 3));
            rsE = REG_AW'($urandom_range(0, 3)); rtE = REG_AW'($urandom_range(0, 3));
            WriteRegE = REG_AW'($urandom_range(0, 3));
            WriteRegM = REG_AW'($urandom_range(0, 3));
            WriteRegW = REG_AW'($urandom_range(0, 3));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemtoRegE = 1'($urandom); MemtoRegM = 1'($urandom);
            BranchD = ($urandom_range(0, 3) == 0); bneD = ($urandom_range(0, 5) == 0);
            jrD = ($urandom_range(0, 5) == 0);
            mdStartD = ($urandom_range(0, 5) == 0); mfhiloD = ($urandom_range(0, 3) == 0);
            mdStartE = ($urandom_range(0, 9) == 0); mdOpE = ($urandom_range(0, 3) == 0);
            if (!reset) reset = 1'b1;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                model_clear();
            end
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
